// File: rtl/cpu_sram_arbiter_pkg.sv
// Shared types for the CPU-to-SRAM arbiter: FSM states, access sizes and the
// registered bus request bundle.
package cpu_sram_arbiter_pkg;

  localparam int ARB_ADDR_W = 32;
  localparam int ARB_DATA_W = 32;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    D_ADDR = 3'd1,
    D_DATA = 3'd2,
    I_ADDR = 3'd3,
    I_DATA = 3'd4
  } arb_state_t;

  typedef enum logic [1:0] {
    MSIZE_B = 2'd0,
    MSIZE_H = 2'd1,
    MSIZE_W = 2'd2
  } msize_t;

  typedef struct packed {
    logic                  req;
    logic                  wr;
    msize_t                size;
    logic [ARB_ADDR_W-1:0] addr;
    logic [ARB_DATA_W-1:0] wdata;
  } sram_req_t;

endpackage

// File: rtl/cpu_sram_arbiter_if.sv
// SRAM-like bus with one outstanding transaction: request/addr_ok handshake
// followed by a data_ok completion.
interface cpu_sram_arbiter_if
  import cpu_sram_arbiter_pkg::*;
#(
  parameter int ADDR_W = ARB_ADDR_W,
  parameter int DATA_W = ARB_DATA_W
);

  logic              req;
  logic              wr;
  msize_t            size;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              addr_ok;
  logic              data_ok;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, wr, size, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, addr, wdata,
    output addr_ok, data_ok, rdata
  );

endinterface

// File: rtl/cpu_sram_arbiter_req_hold.sv
// Registers the bus request on issue and holds every field stable until the
// slave accepts it with addr_ok.
module sram_req_hold
  import cpu_sram_arbiter_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_d,
  input  logic                  load_i,
  input  logic                  addr_ok,
  input  logic                  d_wr,
  input  logic [1:0]            d_size,
  input  logic [ARB_ADDR_W-1:0] d_addr,
  input  logic [ARB_DATA_W-1:0] d_wdata,
  input  logic [ARB_ADDR_W-1:0] i_addr,
  output sram_req_t             req_q
);

  // Only req drops on acceptance; the other fields keep their last value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_q <= '0;
    end else if (load_d) begin
      req_q <= '{req: 1'b1, wr: d_wr, size: msize_t'(d_size),
                 addr: d_addr, wdata: d_wdata};
    end else if (load_i) begin
      req_q <= '{req: 1'b1, wr: 1'b0, size: MSIZE_W,
                 addr: i_addr, wdata: {ARB_DATA_W{1'b0}}};
    end else if (req_q.req && addr_ok) begin
      req_q.req <= 1'b0;
    end
  end

endmodule

// File: rtl/cpu_sram_arbiter.sv
// Merges the MIPS fetch and data ports onto one SRAM-like bus, data first,
// holding a global pipeline stall until every pending access of the cycle is served.
//
// state  | meaning
// IDLE   | no bus activity; pick data, then fetch, if not yet done this cycle
// D_ADDR | data request on the bus, waiting for addr_ok
// D_DATA | data request accepted, waiting for data_ok
// I_ADDR | fetch request on the bus, waiting for addr_ok
// I_DATA | fetch request accepted, waiting for data_ok
module cpu_sram_arbiter
  import cpu_sram_arbiter_pkg::*;
#(
  parameter int ADDR_W = ARB_ADDR_W,
  parameter int DATA_W = ARB_DATA_W
)(
  input  logic                clk,
  input  logic                reset,
  input  logic                i_en,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_en,
  input  logic                d_wr,
  input  logic [1:0]          d_size,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                stall,
  cpu_sram_arbiter_if.master  bus
);

  arb_state_t state;
  logic       i_done;
  logic       d_done;
  logic       d_pend;
  logic       i_pend;
  logic       load_d;
  logic       load_i;
  sram_req_t  req_q;

  assign d_pend = d_en && !d_done;
  assign i_pend = i_en && !i_done;
  assign load_d = (state == IDLE) && d_pend;
  assign load_i = (state == IDLE) && !d_pend && i_pend;

  // Gated by reset so the pipeline never sees a stall while being reset.
  assign stall = !reset && (d_pend || i_pend || (state != IDLE));

  sram_req_hold u_req_hold (
    .clk     (clk),
    .reset   (reset),
    .load_d  (load_d),
    .load_i  (load_i),
    .addr_ok (bus.addr_ok),
    .d_wr    (d_wr),
    .d_size  (d_size),
    .d_addr  (d_addr),
    .d_wdata (d_wdata),
    .i_addr  (i_addr),
    .req_q   (req_q)
  );

  assign bus.req   = req_q.req;
  assign bus.wr    = req_q.wr;
  assign bus.size  = req_q.size;
  assign bus.addr  = req_q.addr;
  assign bus.wdata = req_q.wdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      i_done  <= 1'b0;
      d_done  <= 1'b0;
      i_rdata <= '0;
      d_rdata <= '0;
    end else begin
      // Done flags only matter within one frozen pipeline cycle.
      if (!stall) begin
        i_done <= 1'b0;
        d_done <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (d_pend)      state <= D_ADDR;
          else if (i_pend) state <= I_ADDR;
        end
        D_ADDR: if (bus.addr_ok) state <= D_DATA;
        I_ADDR: if (bus.addr_ok) state <= I_DATA;
        D_DATA: begin
          if (bus.data_ok) begin
            d_done <= 1'b1;
            if (!req_q.wr) d_rdata <= bus.rdata;
            state <= IDLE;
          end
        end
        I_DATA: begin
          if (bus.data_ok) begin
            i_done  <= 1'b1;
            i_rdata <= bus.rdata;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_sram_arbiter.sv
// Bench for cpu_sram_arbiter: directed scenarios plus random pipeline cycles
// served by a randomly delayed bus slave and a transaction-level model.
module tb_cpu_sram_arbiter;
  import cpu_sram_arbiter_pkg::*;

  typedef struct {
    bit          wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          wa;
    int          wd;
  } txn_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_en = 1'b0;
  logic [31:0] i_addr = '0;
  logic [31:0] i_rdata;
  logic        d_en = 1'b0;
  logic        d_wr = 1'b0;
  logic [1:0]  d_size = '0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [31:0] d_rdata;
  logic        stall;

  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] exp_d = '0;
  logic [31:0] exp_i = '0;

  cpu_sram_arbiter_if bus ();

  cpu_sram_arbiter dut (
    .clk     (clk),
    .reset   (reset),
    .i_en    (i_en),
    .i_addr  (i_addr),
    .i_rdata (i_rdata),
    .d_en    (d_en),
    .d_wr    (d_wr),
    .d_size  (d_size),
    .d_addr  (d_addr),
    .d_wdata (d_wdata),
    .d_rdata (d_rdata),
    .stall   (stall),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic txn_t mk(bit wr, logic [1:0] size, logic [31:0] addr,
                              logic [31:0] wdata, logic [31:0] rdata, int wa, int wd);
    txn_t t;
    t.wr = wr; t.size = size; t.addr = addr; t.wdata = wdata;
    t.rdata = rdata; t.wa = wa; t.wd = wd;
    return t;
  endfunction

  // One pipeline cycle: the model expects data before fetch, each access costing
  // 1 issue cycle + (wa+1) address cycles + (wd+1) data cycles of stall.
  task automatic do_step(input string name, input bit de, input txn_t dt,
                         input bit ie, input txn_t it);
    txn_t        q[$];
    int          exp_cyc = 0;
    int          cyc = 0;
    int          cnt = 0;
    bit          phase = 1'b0;
    bit          first = 1'b1;
    logic [34:0] ctl, hctl;
    logic [31:0] hwd;
    txn_t        ft;

    hctl = '0;
    hwd  = '0;
    if (de) begin
      q.push_back(dt);
      exp_cyc += 3 + dt.wa + dt.wd;
      if (!dt.wr) exp_d = dt.rdata;
    end
    if (ie) begin
      ft = it;
      ft.wr = 1'b0;
      ft.size = 2'd2;
      q.push_back(ft);
      exp_cyc += 3 + it.wa + it.wd;
      exp_i = it.rdata;
    end

    @(posedge clk); #1;
    check({name, ":done_clr"}, {62'd0, dut.d_done, dut.i_done}, 64'd0);
    d_en = de; d_wr = dt.wr; d_size = dt.size; d_addr = dt.addr; d_wdata = dt.wdata;
    i_en = ie; i_addr = it.addr;

    for (int c = 0; c < 300; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      bus.addr_ok = 1'b0;
      bus.data_ok = 1'b0;
      bus.rdata   = $urandom;
      if (!phase) begin
        if (bus.req) begin
          ctl = {bus.wr, bus.size, bus.addr};
          if (q.size() == 0) begin
            check({name, ":extra_req"}, {63'd0, bus.req}, 64'd0);
          end else begin
            if (first) begin
              first = 1'b0;
              cnt = 0;
              check({name, ":req_ctl"}, {29'd0, ctl}, {29'd0, q[0].wr, q[0].size, q[0].addr});
              if (q[0].wr) check({name, ":req_wdata"}, {32'd0, bus.wdata}, {32'd0, q[0].wdata});
              hctl = ctl;
              hwd  = bus.wdata;
            end else begin
              check({name, ":hold_ctl"}, {29'd0, ctl}, {29'd0, hctl});
              check({name, ":hold_wdata"}, {32'd0, bus.wdata}, {32'd0, hwd});
            end
            if (cnt == q[0].wa) begin
              bus.addr_ok = 1'b1;
              bus.data_ok = 1'($urandom_range(0, 1));
              phase = 1'b1;
              cnt = 0;
            end else begin
              cnt++;
            end
          end
        end else begin
          bus.data_ok = ($urandom_range(0, 3) == 0);
        end
      end else begin
        if (cnt == q[0].wd) begin
          bus.data_ok = 1'b1;
          bus.rdata   = q[0].rdata;
          void'(q.pop_front());
          phase = 1'b0;
          first = 1'b1;
        end else begin
          cnt++;
        end
      end
      @(negedge clk);
      if (!stall) break;
      cyc++;
    end

    check({name, ":stall_cycles"}, 64'(cyc), 64'(exp_cyc));
    check({name, ":served"}, 64'(q.size()), 64'd0);
    check({name, ":d_rdata"}, {32'd0, d_rdata}, {32'd0, exp_d});
    check({name, ":i_rdata"}, {32'd0, i_rdata}, {32'd0, exp_i});
  endtask

  initial begin
    txn_t none;
    none = mk(1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 0, 0);
    bus.addr_ok = 1'b0;
    bus.data_ok = 1'b0;
    bus.rdata   = '0;

    // Reset state, with requests raised so a missing stall gate would show.
    d_en = 1'b1; i_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_stall", {63'd0, stall}, 64'd0);
    check("rst_req", {60'd0, bus.req, bus.wr, bus.size}, 64'd0);
    check("rst_addr", {32'd0, bus.addr}, 64'd0);
    check("rst_wdata", {32'd0, bus.wdata}, 64'd0);
    check("rst_rdata", {d_rdata, i_rdata}, 64'd0);
    d_en = 1'b0; i_en = 1'b0;
    reset = 1'b0;

    do_step("fetch", 1'b0, none, 1'b1, mk(1'b0, 2'd2, 32'hBFC0_0000, 32'h0, 32'h2408_0001, 0, 0));
    do_step("ld_fetch", 1'b1, mk(1'b0, 2'd2, 32'h8000_0010, 32'h0, 32'hDEAD_BEEF, 0, 0),
            1'b1, mk(1'b0, 2'd2, 32'hBFC0_0004, 32'h0, 32'h0000_0008, 0, 0));
    do_step("st_byte", 1'b1, mk(1'b1, 2'd0, 32'h8000_0003, 32'hAB00_0000, 32'h1111_2222, 0, 0),
            1'b0, none);
    do_step("backpr", 1'b1, mk(1'b0, 2'd2, 32'h8000_0020, 32'h0, 32'hCAFE_F00D, 5, 0),
            1'b0, none);
    for (int k = 0; k < 3; k++)
      do_step("b2b", 1'b0, none, 1'b1,
              mk(1'b0, 2'd2, 32'hBFC0_0008 + 32'(4 * k), 32'h0, 32'h3C00_0000 + 32'(k), 0, 0));

    // Reset while waiting for data_ok; a late data_ok must be ignored.
    @(posedge clk); #1;
    d_en = 1'b1; d_wr = 1'b0; d_size = 2'd2; d_addr = 32'h8000_0040; i_en = 1'b0;
    @(posedge clk); #1;
    bus.addr_ok = 1'b1;
    @(posedge clk); #1;
    bus.addr_ok = 1'b0;
    check("mid_in_ddata", 64'(dut.state), 64'(D_DATA));
    reset = 1'b1;
    #1;
    check("mid_state", 64'(dut.state), 64'(IDLE));
    check("mid_req", {63'd0, bus.req}, 64'd0);
    check("mid_done", {62'd0, dut.d_done, dut.i_done}, 64'd0);
    check("mid_stall", {63'd0, stall}, 64'd0);
    d_en = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    bus.data_ok = 1'b1;
    bus.rdata = 32'h1234_5678;
    @(posedge clk); #1;
    bus.data_ok = 1'b0;
    exp_d = '0;
    exp_i = '0;
    check("late_dok_rdata", {32'd0, d_rdata}, 64'd0);
    check("late_dok_state", 64'(dut.state), 64'(IDLE));
    check("late_dok_stall", {63'd0, stall}, 64'd0);

    for (int k = 0; k < 40; k++) begin
      bit   de, ie;
      txn_t a, b;
      de = 1'($urandom_range(0, 1));
      ie = 1'($urandom_range(0, 1));
      a = mk(1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)), $urandom, $urandom, $urandom,
             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      b = mk(1'b0, 2'd2, {$urandom_range(0, 32'h3FFF_FFFF), 2'b00}, 32'h0, $urandom,
             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      do_step("rand", de, a, ie, b);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
